// File: rtl/sfx_voice_mixer.sv
// Multi-voice square-wave sound-effect generator with a first-order sigma-delta output.
// Optional volume decay envelope enabled by defining SFX_ENVELOPE_EN.
//
// state | meaning
// IDLE  | voice silent, waiting for TRIG
// PLAY  | voice sounding, duration counter running
module sfx_voice_mixer #(
  parameter int CHANNELS     = 4,
  parameter int PERIOD_W     = 16,
  parameter int DUR_W        = 24,
  parameter int VOL_W        = 4,
  parameter int DECAY_CYCLES = 65536
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CHANNELS-1:0]          TRIG,
  input  logic [CHANNELS*PERIOD_W-1:0] PERIOD,
  input  logic [CHANNELS*DUR_W-1:0]    DURATION,
  input  logic [CHANNELS*VOL_W-1:0]    VOLUME,
  input  logic                         MUTE,
  output logic [CHANNELS-1:0]          ACTIVE,
  output logic [CHANNELS-1:0]          DONE,
  output logic                         AUDIO
);

  localparam int SUM_W = VOL_W + $clog2(CHANNELS);

  typedef enum logic {IDLE, PLAY} voice_state_t;

  logic [VOL_W-1:0] contrib [CHANNELS];
  logic [SUM_W-1:0] mix_sum;
  logic [SUM_W-1:0] sample;
  logic [SUM_W:0]   acc;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    voice_state_t      state_q;
    logic              done_q;
    logic              square_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] half_cnt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [VOL_W-1:0]  vol_q;
    logic [PERIOD_W-1:0] period_in;
    logic [DUR_W-1:0]  dur_in;
    logic [VOL_W-1:0]  vol_in;
`ifdef SFX_ENVELOPE_EN
    logic [31:0]       decay_cnt;
`endif

    assign period_in = PERIOD[g*PERIOD_W +: PERIOD_W];
    assign dur_in    = DURATION[g*DUR_W +: DUR_W];
    assign vol_in    = VOLUME[g*VOL_W +: VOL_W];

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q  <= IDLE;
        done_q   <= 1'b0;
        square_q <= 1'b0;
        period_q <= '0;
        half_cnt <= '0;
        dur_cnt  <= '0;
        vol_q    <= '0;
`ifdef SFX_ENVELOPE_EN
        decay_cnt <= '0;
`endif
      end else begin
        done_q <= 1'b0;
        if (TRIG[g]) begin
          // A trigger always wins, even on the cycle the old tone would expire.
          period_q <= period_in;
          half_cnt <= period_in - PERIOD_W'(1);
          square_q <= (period_in != '0);
          dur_cnt  <= dur_in;
          vol_q    <= vol_in;
`ifdef SFX_ENVELOPE_EN
          decay_cnt <= 32'(DECAY_CYCLES - 1);
`endif
          if (dur_in == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= PLAY;
          end
        end else if (state_q == PLAY) begin
          if (dur_cnt == DUR_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          dur_cnt <= dur_cnt - DUR_W'(1);
          if (period_q == '0) begin
            square_q <= 1'b0;
          end else if (half_cnt == '0) begin
            half_cnt <= period_q - PERIOD_W'(1);
            square_q <= ~square_q;
          end else begin
            half_cnt <= half_cnt - PERIOD_W'(1);
          end
`ifdef SFX_ENVELOPE_EN
          if (decay_cnt == '0) begin
            decay_cnt <= 32'(DECAY_CYCLES - 1);
            if (vol_q != '0) vol_q <= vol_q - VOL_W'(1);
          end else begin
            decay_cnt <= decay_cnt - 32'd1;
          end
`endif
        end
      end
    end

    assign ACTIVE[g]  = (state_q == PLAY);
    assign DONE[g]    = done_q;
    assign contrib[g] = (state_q == PLAY && square_q) ? vol_q : '0;
  end

`ifndef SFX_ENVELOPE_EN
  logic [31:0] unused_decay;
  assign unused_decay = 32'(DECAY_CYCLES);
`endif

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mix_sum = mix_sum + SUM_W'(contrib[i]);
    end
  end

  // The carry out of the accumulator is the 1-bit density-modulated stream.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sample <= '0;
      acc    <= '0;
    end else begin
      sample <= MUTE ? '0 : mix_sum;
      acc    <= {1'b0, acc[SUM_W-1:0]} + {1'b0, sample};
    end
  end

  assign AUDIO = acc[SUM_W];

endmodule

// File: doc/sfx_voice_mixer.md
Name: sfx_voice_mixer

Overview:
- Parametrised multi-voice sound-effect generator; successor to the single-tune audio player.
- Each of CHANNELS voices plays a triggered square-wave tone with its own period, duration and volume.
- Voices are summed and converted to a 1-bit first-order sigma-delta stream that drives the audio pin directly.
- Triggered by the game controller on events such as paddle hit, block hit and ball lost.

Parameters:
CHANNELS, 4, number of independent voices
PERIOD_W, 16, width of half-period value (cycles per square-wave half)
DUR_W, 24, width of tone duration (cycles)
VOL_W, 4, width of per-voice volume
DECAY_CYCLES, 65536, cycles per volume decrement (used only with SFX_ENVELOPE_EN)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active high
TRIG  in  CHANNELS  per-voice start pulse
PERIOD  in  CHANNELS*PERIOD_W  per-voice half-period; voice i at bits [i*PERIOD_W +: PERIOD_W]
DURATION  in  CHANNELS*DUR_W  per-voice tone length in cycles
VOLUME  in  CHANNELS*VOL_W  per-voice amplitude
MUTE  in  1  forces mixed sample to 0
ACTIVE  out  CHANNELS  voice i playing
DONE  out  CHANNELS  one-cycle pulse when voice i finishes naturally
AUDIO  out  1  sigma-delta audio bit

Behaviour:
- One clock, CLK. RESET is synchronous and active high.
- Reset state: ACTIVE=0, DONE=0, AUDIO=0. All counters, square levels, the mix register and the accumulator are cleared.
- RESET overrides all other inputs. RESET mid-play silences every voice and produces no DONE.
- Per-voice FSM, IDLE/PLAY:
  - TRIG[i] sampled at cycle t latches PERIOD, DURATION and VOLUME for voice i.
  - It also sets the square level to 1 and loads the half-period counter with PERIOD-1.
- DURATION=D>0:
  - ACTIVE[i]=1 in cycles t+1..t+D.
  - ACTIVE[i]=0 and DONE[i]=1 in cycle t+D+1.
- DURATION=0: no PLAY; DONE[i]=1 at t+1; ACTIVE[i] stays 0.
- Half-period counter, while in PLAY:
  - Decrements each cycle.
  - On reaching 0 it reloads PERIOD-1 and toggles the square level.
  - Result: PERIOD=P gives a 2P-cycle tone.
- PERIOD=0: square level held at 0 (silent), but duration still counts and DONE still fires.
- Retrigger: TRIG[i] while in PLAY restarts the voice with the new values.
  - ACTIVE stays 1.
  - No DONE is issued for the aborted tone.
  - A retrigger in the same cycle as natural expiry wins: no DONE, voice restarts.
- Inputs are latched only on TRIG; changing PERIOD, DURATION or VOLUME mid-tone has no effect.
- Voices are fully independent; simultaneous triggers on any subset are all honoured.
- Mixer:
  - SUM_W = VOL_W + clog2(CHANNELS), which is 6 at the defaults.
  - Registered sample = sum over i of (ACTIVE[i] & square[i] ? vol[i] : 0), zero-extended, no overflow possible.
  - MUTE=1 forces the sample to 0; voices keep running.
- Modulator:
  - Accumulator of width SUM_W+1: acc <= acc[SUM_W-1:0] + sample.
  - AUDIO is the registered carry acc[SUM_W].
  - For a constant sample s, exactly s ones appear per 2^SUM_W consecutive cycles.
- Latency: TRIG at t → voice state at t+1 → sample register at t+2 → AUDIO reflects it from t+3.

Optional Feature:
- SFX_ENVELOPE_EN defined:
  - Each PLAY voice has a DECAY_CYCLES prescaler, restarted on trigger.
  - Every DECAY_CYCLES cycles its working volume decrements by 1, saturating at 0.
  - The voice stays ACTIVE until its duration expires.
- SFX_ENVELOPE_EN undefined: volume constant at its latched value; the prescaler logic is absent.

Test Plan:
- Reset: RESET high 3 cycles with TRIG=4'hF → ACTIVE=0, DONE=0, AUDIO=0 through the cycle after RESET falls.
- Voice 0, PERIOD=4, DURATION=20, VOLUME=15, TRIG[0] at t:
  - ACTIVE[0] high t+1..t+20 (20 cycles).
  - Square toggles every 4 cycles.
  - DONE[0] single pulse at t+21.
- Density: voice 0, PERIOD=1000, DURATION=5000, VOLUME=8 → any 64-cycle window from t+3 to t+999 has exactly 8 ones on AUDIO. All four voices at VOLUME=15 → exactly 60 ones per 64 cycles.
- Retrigger: DURATION=100, retrigger at t+50 with DURATION=10 → ACTIVE continuous t+1..t+60, single DONE at t+61, none at t+101.
- Edge values:
  - DURATION=0 → ACTIVE stays 0, DONE at t+1.
  - PERIOD=0, DURATION=30 → AUDIO all 0, DONE at t+31.
- MUTE and RESET:
  - MUTE=1 during a VOLUME=15 tone → AUDIO 0 within 3 cycles, ACTIVE unchanged.
  - RESET at t+5 of a 20-cycle tone → ACTIVE=0 next cycle, no DONE ever.
  - With SFX_ENVELOPE_EN, DECAY_CYCLES=64, VOLUME=3 → ones per 64-cycle window fall 3,2,1,0.
